// File: rtl/mem_region_router.sv
// Routes one CPU memory request to one of NREG address regions. Each region is either a
// fixed-latency slave or a done-handshake slave; unmapped or timed-out requests raise cpu_err.
module mem_region_router #(
    parameter int unsigned            ADDR_W       = 27,
    parameter int unsigned            DATA_W       = 32,
    parameter int unsigned            NREG         = 4,
    parameter logic [NREG*ADDR_W-1:0] REGION_BASE  = {27'hC00420, 27'hC00000, 27'h800000,
                                                      27'h000000},
    parameter logic [NREG*ADDR_W-1:0] REGION_SIZE  = {27'h002002, 27'h000420, 27'h400000,
                                                      27'h800000},
    parameter logic [NREG-1:0]        REGION_FIXED = 4'b1100,
    parameter int unsigned            TIMEOUT      = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_W-1:0]      cpu_addr,
    input  logic [DATA_W-1:0]      cpu_data,
    input  logic                   cpu_we,
    input  logic                   cpu_start,
    output logic                   cpu_busy,
    output logic [DATA_W-1:0]      cpu_q,
    output logic                   cpu_err,
    output logic [NREG*ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0]      s_d,
    output logic [NREG-1:0]        s_we,
    output logic [NREG-1:0]        s_start,
    input  logic [NREG*DATA_W-1:0] s_q,
    input  logic [NREG-1:0]        s_done
);

    localparam int unsigned IDX_W      = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StErr} state_e;

    state_e                   state_q, state_d;
    logic                     start_q;
    logic                     busy_q, busy_d;
    logic [DATA_W-1:0]        q_q, q_d;
    logic                     err_q, err_d;
    logic [NREG*ADDR_W-1:0]   s_addr_q, s_addr_d;
    logic [DATA_W-1:0]        s_d_q, s_d_d;
    logic [NREG-1:0]          s_we_q, s_we_d;
    logic [NREG-1:0]          s_start_q, s_start_d;
    logic [15:0]              timer_q, timer_d;
    logic [IDX_W-1:0]         sel_q, sel_d;
    logic                     we_q, we_d;

    logic                     hit;
    logic [IDX_W-1:0]         hit_idx;
    logic [ADDR_W-1:0]        hit_off;
    logic [DATA_W-1:0]        sel_data;
    logic                     sel_done;
    logic                     sel_fixed;
    logic                     accept;

    // Scan from the top so the lowest-numbered matching region wins on overlap.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_off = '0;
        for (int k = int'(NREG) - 1; k >= 0; k--) begin
            if ({1'b0, cpu_addr} >= {1'b0, REGION_BASE[k*ADDR_W +: ADDR_W]} &&
                {1'b0, cpu_addr} <  {1'b0, REGION_BASE[k*ADDR_W +: ADDR_W]} +
                                    {1'b0, REGION_SIZE[k*ADDR_W +: ADDR_W]}) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(k);
                hit_off = cpu_addr - REGION_BASE[k*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        sel_data  = '0;
        sel_done  = 1'b0;
        sel_fixed = 1'b0;
        for (int k = 0; k < int'(NREG); k++) begin
            if (sel_q == IDX_W'(k)) begin
                sel_data  = s_q[k*DATA_W +: DATA_W];
                sel_done  = s_done[k];
                sel_fixed = REGION_FIXED[k];
            end
        end
    end

    assign accept = cpu_start && !start_q;

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        q_d       = q_q;
        err_d     = err_q;
        s_addr_d  = s_addr_q;
        s_d_d     = s_d_q;
        s_we_d    = '0;
        s_start_d = '0;
        timer_d   = timer_q;
        sel_d     = sel_q;
        we_d      = we_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    busy_d = 1'b1;
                    sel_d  = hit_idx;
                    we_d   = cpu_we;
                    if (hit) begin
                        state_d = StIssue;
                        err_d   = 1'b0;
                        s_d_d   = cpu_data;
                        for (int k = 0; k < int'(NREG); k++) begin
                            if (hit_idx == IDX_W'(k)) begin
                                s_start_d[k]                = 1'b1;
                                s_we_d[k]                   = cpu_we;
                                s_addr_d[k*ADDR_W +: ADDR_W] = hit_off;
                            end
                        end
                    end else begin
                        state_d = StErr;
                    end
                end
            end
            StErr: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                q_d     = '0;
                err_d   = 1'b1;
            end
            StIssue: begin
                state_d = StWait;
                timer_d = '0;
            end
            StWait: begin
                if (sel_fixed || sel_done) begin
                    state_d  = StIdle;
                    busy_d   = 1'b0;
                    s_addr_d = '0;
                    q_d      = (sel_fixed && we_q) ? '0 : sel_data;
                end else if (timer_q == TIMER_LAST) begin
                    state_d  = StIdle;
                    busy_d   = 1'b0;
                    s_addr_d = '0;
                    q_d      = '0;
                    err_d    = 1'b1;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            q_q       <= '0;
            err_q     <= 1'b0;
            s_addr_q  <= '0;
            s_d_q     <= '0;
            s_we_q    <= '0;
            s_start_q <= '0;
            timer_q   <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= cpu_start;
            busy_q    <= busy_d;
            q_q       <= q_d;
            err_q     <= err_d;
            s_addr_q  <= s_addr_d;
            s_d_q     <= s_d_d;
            s_we_q    <= s_we_d;
            s_start_q <= s_start_d;
            timer_q   <= timer_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
        end
    end

    assign cpu_busy = busy_q;
    assign cpu_q    = q_q;
    assign cpu_err  = err_q;
    assign s_addr   = s_addr_q;
    assign s_d      = s_d_q;
    assign s_we     = s_we_q;
    assign s_start  = s_start_q;

endmodule

// File: tb/tb_mem_region_router.sv
// Bench for mem_region_router: random requests against a transaction-level reference model,
// compared every cycle, plus directed requests with hand-computed expectations.
module tb_mem_region_router;

    localparam int TMO = 8;

    logic         clk;
    logic         reset;
    logic [26:0]  cpu_addr;
    logic [31:0]  cpu_data;
    logic         cpu_we;
    logic         cpu_start;
    logic         cpu_busy;
    logic [31:0]  cpu_q;
    logic         cpu_err;
    logic [107:0] s_addr;
    logic [31:0]  s_d;
    logic [3:0]   s_we;
    logic [3:0]   s_start;
    logic [127:0] s_q;
    logic [3:0]   s_done;

    mem_region_router #(
        .ADDR_W      (27),
        .DATA_W      (32),
        .NREG        (4),
        .REGION_BASE ({27'hC00420, 27'hC00000, 27'h800000, 27'h000000}),
        .REGION_SIZE ({27'h002002, 27'h000420, 27'h400000, 27'h800000}),
        .REGION_FIXED(4'b1100),
        .TIMEOUT     (TMO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cpu_addr (cpu_addr),
        .cpu_data (cpu_data),
        .cpu_we   (cpu_we),
        .cpu_start(cpu_start),
        .cpu_busy (cpu_busy),
        .cpu_q    (cpu_q),
        .cpu_err  (cpu_err),
        .s_addr   (s_addr),
        .s_d      (s_d),
        .s_we     (s_we),
        .s_start  (s_start),
        .s_q      (s_q),
        .s_done   (s_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Region map as plain numbers.
    function automatic longint base_of(input int k);
        case (k)
            0: return 64'h0;
            1: return 64'h800000;
            2: return 64'hC00000;
            default: return 64'hC00420;
        endcase
    endfunction

    function automatic longint size_of(input int k);
        case (k)
            0: return 64'h800000;
            1: return 64'h400000;
            2: return 64'h420;
            default: return 64'h2002;
        endcase
    endfunction

    function automatic bit is_fixed(input int k);
        return (k >= 2);
    endfunction

    function automatic int mdec(input logic [26:0] a);
        for (int k = 0; k < 4; k++)
            if (longint'(a) >= base_of(k) && longint'(a) < base_of(k) + size_of(k)) return k;
        return -1;
    endfunction

    function automatic logic [31:0] sq(input int k);
        return s_q[k*32 +: 32];
    endfunction

    // Reference model: a request is tracked by the number of edges since it was accepted.
    bit           m_busy, m_err, prev_start, cur_we;
    logic [31:0]  m_q, m_d;
    logic [3:0]   m_start, m_we;
    logic [107:0] m_addr;
    int           age, cur_reg;

    task automatic model_finish(input logic [31:0] q, input bit err);
        m_busy = 0;
        m_q    = q;
        m_err  = err;
        m_addr = '0;
    endtask

    task automatic model_step();
        if (!reset) begin
            m_busy = 0; m_err = 0; m_q = 0; m_d = 0; m_start = 0; m_we = 0; m_addr = 0;
            prev_start = 0; age = 0; cur_reg = -1; cur_we = 0;
            return;
        end
        m_start = 0;
        m_we    = 0;
        if (m_busy) begin
            age++;
            if (cur_reg < 0) model_finish(32'h0, 1'b1);
            else if (age >= 2) begin
                if (is_fixed(cur_reg)) model_finish(cur_we ? 32'h0 : sq(cur_reg), 1'b0);
                else if (s_done[cur_reg]) model_finish(sq(cur_reg), 1'b0);
                else if (age - 2 == TMO - 1) model_finish(32'h0, 1'b1);
            end
        end else if (cpu_start && !prev_start) begin
            cur_reg = mdec(cpu_addr);
            cur_we  = cpu_we;
            age     = 0;
            m_busy  = 1;
            if (cur_reg >= 0) begin
                m_err                  = 0;
                m_start[cur_reg]       = 1'b1;
                m_we[cur_reg]          = cpu_we;
                m_addr[cur_reg*27 +: 27] = 27'(longint'(cpu_addr) - base_of(cur_reg));
                m_d                    = cpu_data;
            end
        end
        prev_start = cpu_start;
    endtask

    task automatic monitor();
        forever begin
            @(posedge clk);
            model_step();
            #1;
            chk("cpu_busy", cpu_busy, m_busy);
            chk("cpu_q", cpu_q, m_q);
            chk("cpu_err", cpu_err, m_err);
            chk("s_start", s_start, m_start);
            chk("s_we", s_we, m_we);
            chk("s_addr", s_addr, m_addr);
            chk("s_d", s_d, m_d);
        end
    endtask

    // Observations of the most recent request.
    int           busy_cyc, starts;
    logic [3:0]   last_start, last_we;
    logic [107:0] last_addr;
    logic [31:0]  last_d;

    task automatic drive_slave(input int tgt, input bit tgt_done, input bit rnd_q,
                               input logic [31:0] qval);
        logic [3:0] nd;
        s_q = rnd_q ? {$urandom, $urandom, $urandom, $urandom} : {4{qval}};
        nd  = 4'($urandom_range(0, 15));
        if (tgt >= 0) nd[tgt] = tgt_done;
        s_done = nd;
    endtask

    task automatic observe();
        if (cpu_busy) busy_cyc++;
        if (s_start != 4'h0) begin
            starts++;
            last_start = s_start;
            last_we    = s_we;
            last_addr  = s_addr;
            last_d     = s_d;
        end
    endtask

    // done_at: cycle (edges after accept) at which the target's s_done is sampled high, -1 never.
    task automatic run_req(input logic [26:0] addr, input bit we, input logic [31:0] data,
                           input int done_at, input int hold, input bit rnd_q,
                           input logic [31:0] qval);
        int cyc;
        int tgt;
        bit fin;
        tgt = mdec(addr);
        busy_cyc = 0; starts = 0; last_start = 0; last_we = 0; last_addr = 0; last_d = 0;
        cyc = 0;
        fin = 0;
        while (!fin) begin
            @(negedge clk);
            if (cyc == 0) begin
                cpu_addr  = addr;
                cpu_data  = data;
                cpu_we    = we;
                cpu_start = 1'b1;
            end
            drive_slave(tgt, (cyc == done_at) || (cyc <= 1 && $urandom_range(0, 1) == 1),
                        rnd_q, qval);
            @(posedge clk);
            #1;
            observe();
            cyc++;
            if (!m_busy) fin = 1;
            else if (cyc > 40) begin
                chk("req_complete_bound", 128'(cyc), 128'd40);
                fin = 1;
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            drive_slave(tgt, 1'b0, rnd_q, qval);
            @(posedge clk);
            #1;
            observe();
        end
        @(negedge clk);
        cpu_start = 1'b0;
        s_done    = 4'h0;
        @(posedge clk);
        #1;
    endtask

    task automatic stimulus();
        logic [26:0] a;
        int r;
        int dn;
        reset = 1'b0; cpu_start = 0; cpu_addr = 0; cpu_data = 0; cpu_we = 0;
        s_q = '0; s_done = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", cpu_busy, 0);
        chk("rst_q", cpu_q, 0);
        chk("rst_err", cpu_err, 0);
        chk("rst_s_start", s_start, 0);
        chk("rst_s_addr", s_addr, 0);
        reset = 1'b1;

        chk("mdec_0", 128'(mdec(27'h7FFFFF)), 128'd0);
        chk("mdec_1", 128'(mdec(27'h800000)), 128'd1);
        chk("mdec_hi2", 128'(mdec(27'hC0041F)), 128'd2);
        chk("mdec_lo3", 128'(mdec(27'hC00420)), 128'd3);
        chk("mdec_unmapped", 128'(mdec(27'hD00000) + 1), 128'd0);

        run_req(27'hC00010, 0, 32'h0, -1, 0, 0, 32'hDEADBEEF);
        chk("t1_busy_cyc", 128'(busy_cyc), 128'd2);
        chk("t1_starts", 128'(starts), 128'd1);
        chk("t1_start_vec", last_start, 4'b0100);
        chk("t1_offset", last_addr[54 +: 27], 27'h10);
        chk("t1_q", cpu_q, 32'hDEADBEEF);
        chk("t1_err", cpu_err, 0);

        run_req(27'h000100, 1, 32'h12345678, 5, 0, 0, 32'hA5A5A5A5);
        chk("t2_busy_cyc", 128'(busy_cyc), 128'd5);
        chk("t2_we_vec", last_we, 4'b0001);
        chk("t2_s_d", last_d, 32'h12345678);
        chk("t2_err", cpu_err, 0);

        run_req(27'hD00000, 0, 32'h0, -1, 0, 0, 32'h11111111);
        chk("t3_starts", 128'(starts), 128'd0);
        chk("t3_busy_cyc", 128'(busy_cyc), 128'd1);
        chk("t3_q", cpu_q, 0);
        chk("t3_err", cpu_err, 1);

        run_req(27'h900000, 0, 32'h0, -1, 0, 0, 32'h22222222);
        chk("t4_busy_cyc", 128'(busy_cyc), 128'd9);
        chk("t4_q", cpu_q, 0);
        chk("t4_err", cpu_err, 1);
        run_req(27'hC00004, 0, 32'h0, -1, 0, 0, 32'h33333333);
        chk("t4_err_cleared", cpu_err, 0);
        chk("t4_q_next", cpu_q, 32'h33333333);

        // Done on the last permitted WAIT edge completes normally.
        run_req(27'h800010, 0, 32'h0, 9, 0, 0, 32'h0BADF00D);
        chk("tlast_busy_cyc", 128'(busy_cyc), 128'd9);
        chk("tlast_err", cpu_err, 0);
        chk("tlast_q", cpu_q, 32'h0BADF00D);

        run_req(27'hC00020, 0, 32'h0, -1, 10, 0, 32'h44444444);
        chk("t5_single_start", 128'(starts), 128'd1);
        run_req(27'hC00030, 0, 32'h0, -1, 0, 0, 32'h55555555);
        chk("t5_second_start", 128'(starts), 128'd1);

        run_req(27'hC0041F, 0, 32'h0, -1, 0, 0, 32'h66666666);
        chk("bnd_hi2_vec", last_start, 4'b0100);
        chk("bnd_hi2_off", last_addr[54 +: 27], 27'h41F);
        run_req(27'hC00420, 0, 32'h0, -1, 0, 0, 32'h77777777);
        chk("bnd_lo3_vec", last_start, 4'b1000);
        chk("bnd_lo3_off", last_addr[81 +: 27], 27'h0);

        // Reset in the middle of a handshake request.
        @(negedge clk);
        cpu_addr = 27'h40; cpu_we = 0; cpu_start = 1'b1; s_done = 0; s_q = {4{32'h0000CAFE}};
        repeat (4) @(negedge clk);
        chk("t6_busy_mid", cpu_busy, 1);
        reset = 1'b0;
        #1;
        chk("t6_busy", cpu_busy, 0);
        chk("t6_q", cpu_q, 0);
        chk("t6_err", cpu_err, 0);
        chk("t6_s_addr", s_addr, 0);
        @(negedge clk);
        cpu_start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        s_done = 4'b0001;
        @(negedge clk);
        s_done = 4'b0000;
        @(negedge clk);
        chk("t6_late_done_busy", cpu_busy, 0);
        chk("t6_late_done_q", cpu_q, 0);

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 5);
            a = 27'($urandom);
            if (r < 5) begin
                int k;
                k = $urandom_range(0, 3);
                case (r)
                    0: a = 27'(base_of(k));
                    1: a = 27'(base_of(k) + size_of(k) - 1);
                    2: a = 27'(base_of(k) + size_of(k));
                    default: a = 27'(base_of(k) + longint'($urandom) % size_of(k));
                endcase
            end
            dn = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(2, 11);
            run_req(a, 1'($urandom_range(0, 1)), $urandom, dn, $urandom_range(0, 3), 1, 32'h0);
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        stimulus();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
